// File: rtl/ram32_pkg.sv
// rtl/ram32_pkg.sv - shared constants and state encoding for the 32-deep RAM reader
package ram32_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;
    localparam int MAX_LEN    = RAM_DEPTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/ram32_stream_reader.sv
// rtl/ram32_stream_reader.sv - walks a 32-deep async-read RAM and streams words on valid/ready
module ram32_stream_reader
    import ram32_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);

    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [ADDR_W:0]   remaining, remaining_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              valid_q, valid_nxt;
    logic              last_q, last_nxt;
    logic              done_q, done_nxt;
    logic              beat, load;

    assign beat = valid_q & out_ready;
    // The output register refills whenever it is empty or being drained this cycle.
    assign load = (state == ST_READ) && (remaining != '0) && (!valid_q || out_ready);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        remaining_nxt = remaining;
        data_nxt      = data_q;
        valid_nxt     = valid_q;
        last_nxt      = last_q;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    addr_nxt      = start_addr;
                    remaining_nxt = (length > LEN_MAX) ? LEN_MAX : length;
                    state_nxt     = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_nxt     = ST_IDLE;
                    valid_nxt     = 1'b0;
                    last_nxt      = 1'b0;
                    remaining_nxt = '0;
                end else if (load) begin
                    data_nxt      = ram_data;
                    valid_nxt     = 1'b1;
                    last_nxt      = (remaining == (ADDR_W + 1)'(1));
                    addr_nxt      = addr_q + ADDR_W'(1);
                    remaining_nxt = remaining - (ADDR_W + 1)'(1);
                end else if ((remaining == '0) && beat) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            remaining <= remaining_nxt;
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            last_q    <= last_nxt;
            done_q    <= done_nxt;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_ram32_stream_reader.sv
// tb/tb_ram32_stream_reader.sv - randomized self-checking bench for ram32_stream_reader
module tb_ram32_stream_reader;
    import ram32_pkg::*;

    localparam int DW = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, out_data;

    // ram32_model: synchronous write, asynchronous read
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem   [RAM_DEPTH];
    logic [DW-1:0] model [RAM_DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) mem[waddr] <= wdata;
    assign ram_data = mem[ram_addr];

    ram32_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_data(ram_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic ram_write(input int a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a[AW-1:0]; wdata = d;
        model[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where done (or the abort result) is seen.
    // mode: 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0,1,0,1 on valid cycles
    task automatic run_cmd(input int sa, input int len, input int mode, input int abort_at,
                           input bit mid_start, input bit mid_write);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        logic          hl;
        logic [5:0]    pat;
        int n, idx, cyc, pi, la;
        bit fin, stall, aborted, seen_v;
        pat = 6'b101001;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++) exp_q.push_back(model[(sa + i) % RAM_DEPTH]);
        start = 1'b1; start_addr = sa[AW-1:0]; length = len[AW:0]; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            for (int c = 0; c < 3; c++) begin
                check("zero_busy", busy, 0);
                check("zero_valid", out_valid, 0);
                check("zero_done", done, 0);
                @(negedge clk);
            end
            return;
        end
        check("cmd_addr", ram_addr, sa);
        check("cmd_busy", busy, 1);
        check("cmd_valid", out_valid, 0);
        check("cmd_done", done, 0);
        cyc = 1; idx = 0; pi = 0; fin = 0; stall = 0; aborted = 0; seen_v = 0;
        hd = '0; ha = '0; hl = 1'b0;
        while (!fin && cyc < 300) begin
            if (aborted) begin
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                abort = 1'b0;
                @(negedge clk);
                check("abort_no_done", done, 0);
                fin = 1;
            end else if (done) begin
                check("done_beats", idx, n);
                if (mode == 0) check("done_cycle", cyc, n + 2);
                check("done_busy", busy, 0);
                check("done_valid", out_valid, 0);
                check("end_addr", ram_addr, (sa + n) % RAM_DEPTH);
                fin = 1;
            end else begin
                if (stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hd);
                    check("hold_last", out_last, hl);
                    check("hold_addr", ram_addr, ha);
                end
                if (out_valid && !seen_v) begin
                    seen_v = 1;
                    check("latency", cyc, 2);
                end
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (out_valid && pi < 6) begin
                            out_ready = pat[pi];
                            pi++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (out_valid && out_ready) begin
                    if (idx < n) check("data", out_data, exp_q[idx]);
                    else check("extra_beat", idx, n - 1);
                    la = (idx == n - 1) ? 1 : 0;
                    check("last", out_last, la);
                    idx++;
                end
                stall = out_valid && !out_ready;
                hd = out_data; hl = out_last; ha = ram_addr;
                if (mid_start && cyc == 3) begin
                    start = 1'b1; start_addr = 5'd10; length = 6'd5;
                end else begin
                    start = 1'b0;
                end
                if (mid_write && cyc == 1 && n >= 4) begin
                    we = 1'b1;
                    waddr = 5'((sa + n - 1) % RAM_DEPTH);
                    wdata = model[(sa + n - 1) % RAM_DEPTH] ^ 2'b11;
                    model[(sa + n - 1) % RAM_DEPTH] = wdata;
                    exp_q[n - 1] = wdata;
                end else begin
                    we = 1'b0;
                end
                if (abort_at > 0 && idx == abort_at) begin
                    abort = 1'b1;
                    aborted = 1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("timeout", 0, 1);
        start = 1'b0; we = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int sa, len;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_addr = '0; length = '0; we = 1'b0; waddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < RAM_DEPTH; i++) ram_write(i, DW'(i % 4));

        run_cmd(4, 4, 0, 0, 0, 0);
        run_cmd(30, 4, 0, 0, 0, 0);
        run_cmd(5, 3, 2, 0, 0, 0);
        run_cmd(7, 0, 0, 0, 0, 0);
        run_cmd(12, 6, 0, 0, 1, 0);
        run_cmd(0, 32, 0, 0, 0, 0);
        run_cmd(0, 40, 0, 0, 0, 0);
        run_cmd(3, 6, 0, 2, 0, 0);

        // reset in the middle of a transfer
        start = 1'b1; start_addr = 5'd20; length = 6'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_last", out_last, 0);
        check("mrst_data", out_data, 0);
        check("mrst_addr", ram_addr, 0);
        check("mrst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_no_done", done, 0);
        run_cmd(9, 5, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int w = 0; w < 3; w++) ram_write(int'($urandom_range(0, 31)), DW'($urandom));
            end
            sa = int'($urandom_range(0, 31));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32));
            run_cmd(sa, len, 1, ($urandom_range(0, 7) == 0 && len > 4) ? 2 : 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
